uart_memctrl_rx: RTL and testbench
==================================

// Module: uart_memctrl_rx
// PURPOSE
//  Memory-controller-side receiver for the serial stream from the bus UART transmitter.
//  - Frame format: 1 start (0), DATA_WIDTH data bits LSB first, 1 even-parity bit, 1 stop (1).
//  - Each burst is armed by the transmitter's read-ready strobe. The block deserialises
//    word_number frames and issues one memory write per good frame, at incrementing addresses.
//  - Parity and framing faults are flagged back toward the bus side.
// PARAMETERS
//  DATA_WIDTH     32  payload bits per frame
//  ADDR_WIDTH     32  memory address width
//  WNUM_WIDTH     8   width of word_number (burst length)
//  CLKS_PER_BIT   1   clk cycles per serial bit (>=1)
//  SYNC_STAGES    2   rx synchroniser flops (0 = none)
//  ADDR_STEP      1   address increment per word
// PORTS
//  clk             in   1           system clock, rising edge
//  reset           in   1           asynchronous reset, active-low
//  rx              in   1           serial data from transmitter tx; idles high
//  read_ready      in   1           1-cycle burst arm strobe from transmitter
//  base_addr       in   ADDR_WIDTH  first write address; latched on arm
//  word_number     in   WNUM_WIDTH  frames in burst; latched on arm
//  mem_we          out  1           1-cycle write strobe
//  mem_addr        out  ADDR_WIDTH  write address, valid with mem_we
//  mem_wdata       out  DATA_WIDTH  write data, valid with mem_we
//  busy            out  1           burst armed and not finished
//  burst_done      out  1           1-cycle pulse at end of burst
//  parity_error    out  1           sticky; cleared on next arm
//  frame_error     out  1           sticky; cleared on next arm
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; all outputs 0; counters 0; sync flops 1.
//  - States: IDLE -> ARMED -> START -> DATA -> PARITY -> STOP -> (ARMED | DONE | WAIT_HIGH).
//  - IDLE:
//      - read_ready=1: latch base_addr and word_number, clear sticky errors, set busy.
//      - If word_number==0: go to DONE. Otherwise go to ARMED.
//      - rx activity in IDLE is ignored.
//  - ARMED: synchronised rx==0 enters START.
//  - START:
//      - Wait CLKS_PER_BIT/2 cycles (integer division; 0 when CLKS_PER_BIT=1), then resample.
//      - Resampled 1 = false start: return to ARMED.
//      - Resampled 0: go to DATA.
//  - DATA: sample every CLKS_PER_BIT cycles; shift LSB first; exactly DATA_WIDTH samples.
//  - PARITY: one sample. Parity ok when XOR(data bits, parity bit)==0 (even parity).
//  - STOP:
//      - Sample stop bit; the frame's result is decided here.
//      - stop==1, parity ok: mem_we=1 on the next cycle, with mem_addr = base + idx*ADDR_STEP
//        and mem_wdata = data.
//      - stop==1, parity bad: set parity_error; no write; frame still consumed.
//      - stop==0: set frame_error; no write; frame consumed; go to WAIT_HIGH.
//      - After STOP, idx++. If idx==word_number go to DONE, else ARMED.
//  - WAIT_HIGH: stay until synced rx==1, then continue as the STOP exit above (DONE or ARMED).
//  - DONE: burst_done=1 for one cycle, busy=0, return to IDLE.
//  - Arithmetic:
//      - Address wraps modulo 2^ADDR_WIDTH.
//      - idx is WNUM_WIDTH wide; max burst is 2^WNUM_WIDTH-1.
//  - read_ready while busy: ignored; no relatch, no error.
//  - Latency: rx edge to sampling = SYNC_STAGES cycles. mem_we rises 1 cycle after the stop sample.
//  - Back-to-back frames (next start immediately after stop) must be accepted without gap.
//  - Reset mid-frame aborts: partial word discarded, no write, no burst_done.
// STRUCTURE
//  - Shared `define header (uart_defines.vh): state encodings, parity mode, RW/ready enables,
//    bus/addr/word-number widths; shared with the transmitter.
//  - One sub-module: uart_rx_deser.
//      - Contains the synchroniser, bit timer and shift/parity logic.
//      - Outputs frame_valid, frame_data, parity_ok, stop_ok.
//  - Burst FSM, address/index counters and sticky flags remain in uart_memctrl_rx.
// TESTING
//  T1 arm base=0x0000_0001, wn=4; send 0x11, 0x1001, 0x1111, 0x11 with good parity
//     -> 4 mem_we pulses at addr 1,2,3,4 with matching data; burst_done once; errors 0.
//  T2 wn=2; frame 0 parity flipped, frame 1 = 0xA5A5_A5A5
//     -> parity_error=1, single write addr=base+1 data=0xA5A5_A5A5, burst_done.
//  T3 wn=1; stop bit driven 0 for 3 bits, then rx high
//     -> frame_error=1, no write, burst_done after rx returns high.
//  T4 CLKS_PER_BIT=16; 4-cycle low glitch, then valid frame 0xDEAD_BEEF
//     -> glitch ignored, one write 0xDEAD_BEEF.
//  T5 wn=0 -> burst_done 1 cycle after arm, no writes;
//     base=0xFFFF_FFFF, wn=2 -> writes at 0xFFFF_FFFF then 0x0000_0000.
//  T6 reset low mid-DATA of frame 2
//     -> outputs 0 immediately, no write; new arm then completes normally.

Source files
------------

// File: rtl/uart_memctrl_rx_pkg.sv
// Shared types and default sizing for the memory-controller-side UART burst receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the serial link has no flow control, only the read-ready arm strobe.
package uart_memctrl_rx_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_WNUM_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 1;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_ADDR_STEP    = 1;

    // Burst-level control: frame reception itself is tracked by the deserialiser.
    typedef enum logic [1:0] {
        BS_IDLE      = 2'd0,
        BS_ARMED     = 2'd1,
        BS_WAIT_HIGH = 2'd2,
        BS_DONE      = 2'd3
    } burst_state_e;

    // Position inside one serial frame.
    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_START  = 3'd1,
        DS_DATA   = 3'd2,
        DS_PARITY = 3'd3,
        DS_STOP   = 3'd4
    } deser_state_e;

endpackage

// File: rtl/uart_memctrl_rx_deser.sv
// Frame deserialiser: rx synchroniser, bit timer, LSB-first shift and even-parity check.
// Latency: SYNC_STAGES cycles from rx edge to sampling; frame_valid_o is asserted in the stop-sample cycle.
// Backpressure: none; a new start bit is only looked for while en_i is high.
module uart_memctrl_rx_deser
    import uart_memctrl_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    input  logic                  en_i,
    output logic                  rx_sync_o,
    output logic                  frame_valid_o,
    output logic [DATA_WIDTH-1:0] frame_data_o,
    output logic                  parity_ok_o,
    output logic                  stop_ok_o
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    logic                  rx_s;
    deser_state_e          state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_ok_q;
    logic                  tick;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign rx_s = rx_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        // Metastability chain; resets to the idle (high) line level.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) sync_q <= '1;
            else         sync_q <= (sync_q << 1) | SYNC_STAGES'(rx_i);
        end
        assign rx_s = sync_q[SYNC_STAGES-1];
    end

    // One bit period has elapsed; with one clock per bit this is every cycle.
    assign tick = (cnt_q == CNT_LAST);

    // Frame walker: the detecting sample counts as cycle 0 of the start bit, so mid-bit
    // resampling lands HALF cycles later and every later sample one full bit after that.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= DS_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            par_ok_q <= 1'b0;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (en_i && !rx_s) begin
                        if (HALF == 0) begin
                            state_q <= DS_DATA;
                        end else begin
                            state_q <= DS_START;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                DS_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? DS_IDLE : DS_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DS_DATA: begin
                    if (tick) begin
                        cnt_q  <= '0;
                        data_q <= {rx_s, data_q[DATA_WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= DS_PARITY;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DS_PARITY: begin
                    if (tick) begin
                        cnt_q    <= '0;
                        par_ok_q <= ~(^{data_q, rx_s});
                        state_q  <= DS_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DS_STOP: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= DS_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= DS_IDLE;
            endcase
        end
    end

    assign rx_sync_o     = rx_s;
    assign frame_valid_o = (state_q == DS_STOP) && tick;
    assign frame_data_o  = data_q;
    assign parity_ok_o   = par_ok_q;
    assign stop_ok_o     = rx_s;

endmodule

// File: rtl/uart_memctrl_rx.sv
// Burst receiver: turns word_number serial frames into memory writes at incrementing addresses.
// Latency: mem_we_o one cycle after the stop-bit sample; burst_done_o one cycle after the burst ends.
// Backpressure: none; read_ready_i while busy is ignored and memory writes cannot be stalled.
module uart_memctrl_rx
    import uart_memctrl_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WNUM_WIDTH   = DEF_WNUM_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int ADDR_STEP    = DEF_ADDR_STEP
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    input  logic                  read_ready_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [WNUM_WIDTH-1:0] word_number_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  busy_o,
    output logic                  burst_done_o,
    output logic                  parity_error_o,
    output logic                  frame_error_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    burst_state_e          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WNUM_WIDTH-1:0] wnum_q;
    logic [WNUM_WIDTH-1:0] idx_q;
    logic [WNUM_WIDTH-1:0] idx_inc;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  perr_q;
    logic                  ferr_q;

    logic                  rx_sync;
    logic                  frame_valid;
    logic [DATA_WIDTH-1:0] frame_data;
    logic                  parity_ok;
    logic                  stop_ok;

    uart_memctrl_rx_deser #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_deser (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rx_i          (rx_i),
        .en_i          (state_q == BS_ARMED),
        .rx_sync_o     (rx_sync),
        .frame_valid_o (frame_valid),
        .frame_data_o  (frame_data),
        .parity_ok_o   (parity_ok),
        .stop_ok_o     (stop_ok)
    );

    assign idx_inc = idx_q + 1'b1;

    // Burst sequencing: a running address register gives base + idx*STEP with natural wrap,
    // and it advances on every consumed frame, good or bad.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BS_IDLE;
            addr_q      <= '0;
            wnum_q      <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                BS_IDLE: begin
                    if (read_ready_i) begin
                        addr_q  <= base_addr_i;
                        wnum_q  <= word_number_i;
                        idx_q   <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (word_number_i == '0) ? BS_DONE : BS_ARMED;
                    end
                end
                BS_ARMED: begin
                    if (frame_valid) begin
                        idx_q  <= idx_inc;
                        addr_q <= addr_q + STEP;
                        if (stop_ok) begin
                            if (parity_ok) begin
                                we_q        <= 1'b1;
                                mem_addr_q  <= addr_q;
                                mem_wdata_q <= frame_data;
                            end else begin
                                perr_q <= 1'b1;
                            end
                            state_q <= (idx_inc == wnum_q) ? BS_DONE : BS_ARMED;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BS_WAIT_HIGH;
                        end
                    end
                end
                BS_WAIT_HIGH: begin
                    if (rx_sync) state_q <= (idx_q == wnum_q) ? BS_DONE : BS_ARMED;
                end
                BS_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= BS_IDLE;
                end
                default: state_q <= BS_IDLE;
            endcase
        end
    end

    assign mem_we_o       = we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign busy_o         = busy_q;
    assign burst_done_o   = done_q;
    assign parity_error_o = perr_q;
    assign frame_error_o  = ferr_q;

endmodule

// File: tb/tb_uart_memctrl_rx.sv
// Bench for uart_memctrl_rx: one instance at 1 clk/bit (a) and one at 16 clk/bit (b).
// Writes are captured by a negedge monitor; tests push expected writes and compare in order.
// Each test task checks its own results inline.
module tb_uart_memctrl_rx;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        rx_a, rx_b;
    logic        rr_a, rr_b;
    logic [31:0] base_addr;
    logic [7:0]  word_number;

    logic        we_a, busy_a, done_a, perr_a, ferr_a;
    logic [31:0] addr_a, wdata_a;
    logic        we_b, busy_b, done_b, perr_b, ferr_b;
    logic [31:0] addr_b, wdata_b;

    wr_t exp_a[$], exp_b[$];
    wr_t obs_a[$], obs_b[$];
    int  rd_a = 0, rd_b = 0;
    int  bd_a = 0, bd_b = 0;
    int  checks = 0, errors = 0;

    uart_memctrl_rx #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WNUM_WIDTH(8),
        .CLKS_PER_BIT(1), .SYNC_STAGES(2), .ADDR_STEP(1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .read_ready_i(rr_a),
        .base_addr_i(base_addr), .word_number_i(word_number),
        .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a),
        .busy_o(busy_a), .burst_done_o(done_a),
        .parity_error_o(perr_a), .frame_error_o(ferr_a)
    );

    uart_memctrl_rx #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WNUM_WIDTH(8),
        .CLKS_PER_BIT(16), .SYNC_STAGES(2), .ADDR_STEP(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .read_ready_i(rr_b),
        .base_addr_i(base_addr), .word_number_i(word_number),
        .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
        .busy_o(busy_b), .burst_done_o(done_b),
        .parity_error_o(perr_b), .frame_error_o(ferr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_a)   obs_a.push_back({addr_a, wdata_a});
            if (we_b)   obs_b.push_back({addr_b, wdata_b});
            if (done_a) bd_a++;
            if (done_b) bd_b++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        tick(sel ? 16 : 1);
    endtask

    task automatic send_frame(input bit sel, input logic [31:0] d, input bit bad_par, input logic stop_v);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 32; i++) drive_bit(sel, d[i]);
        drive_bit(sel, (^d) ^ bad_par);
        drive_bit(sel, stop_v);
    endtask

    task automatic arm(input bit sel, input logic [31:0] base, input logic [7:0] wn);
        base_addr   = base;
        word_number = wn;
        if (sel) rr_b = 1'b1;
        else     rr_a = 1'b1;
        tick(1);
        rr_a = 1'b0;
        rr_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int bd0, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if ((sel ? bd_b : bd_a) != bd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rr_a = 1'b0; rr_b = 1'b0;
        base_addr = '0; word_number = '0;
        tick(3);
        checks++;
        if ({we_a, busy_a, done_a, perr_a, ferr_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got we/busy/done/perr/ferr=%b, want 00000", {we_a, busy_a, done_a, perr_a, ferr_a});
        end
        checks++;
        if ({addr_a, wdata_a} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus_a: got addr=%h data=%h, want 0", addr_a, wdata_a);
        end
        checks++;
        if ({we_b, busy_b, done_b, perr_b, ferr_b, addr_b, wdata_b} !== 69'h0) begin
            errors++;
            $display("FAIL reset_b: got we=%b busy=%b addr=%h data=%h, want all 0", we_b, busy_b, addr_b, wdata_b);
        end
        rst_n = 1'b1;
        tick(3);
    endtask

    // T1 plus back-to-back frames and an ignored re-arm while busy.
    task automatic test_burst();
        logic [31:0] d[4] = '{32'h11, 32'h1001, 32'h1111, 32'h11};
        int bd0 = bd_a;
        bit ok;
        wr_t e, o;
        arm(0, 32'h1, 8'd4);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b, want 1", busy_a); end
        arm(0, 32'h999, 8'd7);
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back({32'(1 + i), d[i]});
            send_frame(0, d[i], 1'b0, 1'b1);
        end
        wait_done(0, bd0, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL burst_done_timeout: got no pulse, want one"); end
        tick(5);
        checks++;
        if (bd_a - bd0 != 1) begin errors++; $display("FAIL burst_done_count: got %0d, want 1", bd_a - bd0); end
        checks++;
        if ({perr_a, ferr_a, busy_a} !== 3'b000) begin
            errors++; $display("FAIL burst_flags: got perr/ferr/busy=%b, want 000", {perr_a, ferr_a, busy_a});
        end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (rd_a >= obs_a.size()) begin
                errors++; $display("FAIL burst_write: missing, want addr=%h data=%h", e.addr, e.data);
            end else begin
                o = obs_a[rd_a]; rd_a++;
                if (o !== e) begin
                    errors++; $display("FAIL burst_write: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_a.size() != rd_a) begin errors++; $display("FAIL burst_extra: got %0d extra writes, want 0", obs_a.size() - rd_a); end
    endtask

    // T2
    task automatic test_parity();
        int bd0 = bd_a;
        bit ok;
        wr_t e, o;
        arm(0, 32'h100, 8'd2);
        send_frame(0, 32'h1234_5678, 1'b1, 1'b1);
        exp_a.push_back({32'h101, 32'hA5A5_A5A5});
        send_frame(0, 32'hA5A5_A5A5, 1'b0, 1'b1);
        wait_done(0, bd0, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL parity_done_timeout: got no pulse, want one"); end
        tick(2);
        checks++;
        if ({perr_a, ferr_a} !== 2'b10) begin errors++; $display("FAIL parity_flags: got perr/ferr=%b, want 10", {perr_a, ferr_a}); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (rd_a >= obs_a.size()) begin
                errors++; $display("FAIL parity_write: missing, want addr=%h data=%h", e.addr, e.data);
            end else begin
                o = obs_a[rd_a]; rd_a++;
                if (o !== e) begin
                    errors++; $display("FAIL parity_write: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_a.size() != rd_a) begin errors++; $display("FAIL parity_extra: got %0d extra writes, want 0", obs_a.size() - rd_a); end
    endtask

    // T3
    task automatic test_framing();
        int bd0 = bd_a;
        bit ok;
        arm(0, 32'h200, 8'd1);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 32; i++) drive_bit(0, 1'b1 ^ i[0]);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
        tick(3);
        checks++;
        if ({busy_a, ferr_a, perr_a} !== 3'b110 || bd_a != bd0) begin
            errors++; $display("FAIL framing_hold: got busy/ferr/perr=%b dones=%0d, want 110 and 0", {busy_a, ferr_a, perr_a}, bd_a - bd0);
        end
        rx_a = 1'b1;
        wait_done(0, bd0, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL framing_done_timeout: got no pulse, want one"); end
        tick(2);
        checks++;
        if (obs_a.size() != rd_a) begin errors++; $display("FAIL framing_write: got %0d writes, want 0", obs_a.size() - rd_a); end
        checks++;
        if (ferr_a !== 1'b1) begin errors++; $display("FAIL framing_sticky: got %b, want 1", ferr_a); end
    endtask

    // T4 on the 16 clk/bit instance.
    task automatic test_glitch();
        int bd0 = bd_b;
        bit ok;
        wr_t e, o;
        arm(1, 32'h40, 8'd1);
        rx_b = 1'b0;
        tick(4);
        rx_b = 1'b1;
        tick(40);
        checks++;
        if (busy_b !== 1'b1 || obs_b.size() != rd_b || {perr_b, ferr_b} !== 2'b00) begin
            errors++; $display("FAIL glitch_state: got busy=%b writes=%0d perr/ferr=%b, want 1, 0, 00", busy_b, obs_b.size() - rd_b, {perr_b, ferr_b});
        end
        exp_b.push_back({32'h40, 32'hDEAD_BEEF});
        send_frame(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_done(1, bd0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL glitch_done_timeout: got no pulse, want one"); end
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            checks++;
            if (rd_b >= obs_b.size()) begin
                errors++; $display("FAIL glitch_write: missing, want addr=%h data=%h", e.addr, e.data);
            end else begin
                o = obs_b[rd_b]; rd_b++;
                if (o !== e) begin
                    errors++; $display("FAIL glitch_write: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_b.size() != rd_b || {perr_b, ferr_b} !== 2'b00) begin
            errors++; $display("FAIL glitch_end: got extra=%0d perr/ferr=%b, want 0 and 00", obs_b.size() - rd_b, {perr_b, ferr_b});
        end
    endtask

    // T5: empty burst, then address wrap.
    task automatic test_boundary();
        int bd0 = bd_a;
        bit ok;
        wr_t e, o;
        arm(0, 32'h300, 8'd0);
        tick(2);
        checks++;
        if (bd_a - bd0 != 1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL empty_burst: got dones=%0d busy=%b, want 1 and 0", bd_a - bd0, busy_a);
        end
        checks++;
        if (obs_a.size() != rd_a) begin errors++; $display("FAIL empty_write: got %0d writes, want 0", obs_a.size() - rd_a); end
        bd0 = bd_a;
        arm(0, 32'hFFFF_FFFF, 8'd2);
        exp_a.push_back({32'hFFFF_FFFF, 32'h0BAD_F00D});
        send_frame(0, 32'h0BAD_F00D, 1'b0, 1'b1);
        exp_a.push_back({32'h0000_0000, 32'h8000_0001});
        send_frame(0, 32'h8000_0001, 1'b0, 1'b1);
        wait_done(0, bd0, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_done_timeout: got no pulse, want one"); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (rd_a >= obs_a.size()) begin
                errors++; $display("FAIL wrap_write: missing, want addr=%h data=%h", e.addr, e.data);
            end else begin
                o = obs_a[rd_a]; rd_a++;
                if (o !== e) begin
                    errors++; $display("FAIL wrap_write: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
    endtask

    // T6
    task automatic test_reset_abort();
        int bd0 = bd_a;
        bit ok;
        wr_t e, o;
        arm(0, 32'h500, 8'd3);
        exp_a.push_back({32'h500, 32'hCAFE_0000});
        send_frame(0, 32'hCAFE_0000, 1'b0, 1'b1);
        exp_a.push_back({32'h501, 32'hCAFE_0001});
        send_frame(0, 32'hCAFE_0001, 1'b0, 1'b1);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 10; i++) drive_bit(0, 1'b1 ^ i[0]);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we_a, busy_a, done_a, perr_a, ferr_a, addr_a, wdata_a} !== 69'h0) begin
            errors++; $display("FAIL abort_outputs: got busy=%b we=%b addr=%h data=%h, want all 0", busy_a, we_a, addr_a, wdata_a);
        end
        tick(3);
        rx_a = 1'b1;
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (bd_a != bd0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL abort_done: got dones=%0d busy=%b, want 0 and 0", bd_a - bd0, busy_a);
        end
        arm(0, 32'h600, 8'd1);
        exp_a.push_back({32'h600, 32'h7654_3210});
        send_frame(0, 32'h7654_3210, 1'b0, 1'b1);
        wait_done(0, bd0, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_rearm_timeout: got no pulse, want one"); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (rd_a >= obs_a.size()) begin
                errors++; $display("FAIL abort_write: missing, want addr=%h data=%h", e.addr, e.data);
            end else begin
                o = obs_a[rd_a]; rd_a++;
                if (o !== e) begin
                    errors++; $display("FAIL abort_write: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        tick(3);
        checks++;
        if (obs_a.size() != rd_a || bd_a - bd0 != 1) begin
            errors++; $display("FAIL abort_end: got extra=%0d dones=%0d, want 0 and 1", obs_a.size() - rd_a, bd_a - bd0);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_parity();
        test_framing();
        test_glitch();
        test_boundary();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
